// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package addsub_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_seq_fa_cell.sv
// Combinational 1-bit full adder shared by every bit step of addsub_seq.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_seq.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, through a
// single full-adder cell. Subtraction is A + ~B + 1.
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             Gl_rst,
  input  logic             Gl_adder_start,
  input  logic             Gl_subtract,
  input  logic [WIDTH-1:0] Gl_r1,
  input  logic [WIDTH-1:0] Gl_r2,
  output logic [WIDTH-1:0] L2_adder_data,
  output logic             L2_adder_rdy,
  output logic             L2_busy,
  output logic             L2_cout,
  output logic             L2_ovf,
  output logic [7:0]       L2_led
);

  localparam int IDX_W = $clog2(WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sreg;
  logic [WIDTH-1:0] b_sreg;
  logic [WIDTH-1:0] sum_sreg;
  logic             carry;
  logic             sub_flag;
  logic [IDX_W-1:0] idx;
  logic [3:0]       op_count;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_next;

  // Operands shift right each step, so bit idx of the original value is
  // always presented at position 0.
  fa_cell u_fa (
    .a   (a_sreg[0]),
    .b   (b_sreg[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  assign sum_next = {fa_sum, sum_sreg[WIDTH-1:1]};
  assign L2_led   = {op_count, L2_busy, sub_flag, L2_ovf, L2_cout};

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, matching the hardware it describes.
  always_ff @(posedge clk or posedge Gl_rst) begin
    if (Gl_rst) begin
      state         <= IDLE;
      a_sreg        <= '0;
      b_sreg        <= '0;
      sum_sreg      <= '0;
      carry         <= 1'b0;
      sub_flag      <= 1'b0;
      idx           <= '0;
      op_count      <= '0;
      L2_adder_data <= '0;
      L2_adder_rdy  <= 1'b0;
      L2_busy       <= 1'b0;
      L2_cout       <= 1'b0;
      L2_ovf        <= 1'b0;
    end else begin
      L2_adder_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (Gl_adder_start) begin
            a_sreg   <= Gl_r1;
            b_sreg   <= Gl_r2 ^ {WIDTH{Gl_subtract}};
            carry    <= Gl_subtract;
            sub_flag <= Gl_subtract;
            idx      <= '0;
            L2_busy  <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_sreg <= sum_next;
          a_sreg   <= a_sreg >> 1;
          b_sreg   <= b_sreg >> 1;
          carry    <= fa_cout;
          idx      <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // carry still holds the carry into the MSB on this step
            L2_adder_data <= sum_next;
            L2_cout       <= fa_cout;
            L2_ovf        <= carry ^ fa_cout;
            L2_adder_rdy  <= 1'b1;
            op_count      <= op_count + 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          L2_busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed self-checking bench for addsub_seq (WIDTH = 8).
module tb_addsub_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         Gl_rst;
  logic         Gl_adder_start;
  logic         Gl_subtract;
  logic [W-1:0] Gl_r1;
  logic [W-1:0] Gl_r2;
  logic [W-1:0] L2_adder_data;
  logic         L2_adder_rdy;
  logic         L2_busy;
  logic         L2_cout;
  logic         L2_ovf;
  logic [7:0]   L2_led;

  int vectors     = 0;
  int miscompares = 0;

  addsub_seq #(.WIDTH(W)) dut (
    .clk           (clk),
    .Gl_rst        (Gl_rst),
    .Gl_adder_start(Gl_adder_start),
    .Gl_subtract   (Gl_subtract),
    .Gl_r1         (Gl_r1),
    .Gl_r2         (Gl_r2),
    .L2_adder_data (L2_adder_data),
    .L2_adder_rdy  (L2_adder_rdy),
    .L2_busy       (L2_busy),
    .L2_cout       (L2_cout),
    .L2_ovf        (L2_ovf),
    .L2_led        (L2_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation: start for one cycle, wait for rdy, check result,
  // latency, the DONE-cycle LED word and that rdy drops after one cycle.
  task automatic do_op(input string tag, input logic [W-1:0] r1, input logic [W-1:0] r2,
                       input logic sub, input logic [W-1:0] exp_data, input logic exp_cout,
                       input logic exp_ovf, input logic [7:0] exp_led);
    int  n;
    bit  got;
    @(negedge clk);
    Gl_r1 = r1; Gl_r2 = r2; Gl_subtract = sub; Gl_adder_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Gl_adder_start = 1'b0;
    check({tag, ".busy"}, 32'(L2_busy), 32'd1);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (L2_adder_rdy) got = 1'b1;
    end
    check({tag, ".latency"}, 32'(n), 32'(W));
    check({tag, ".data"}, 32'(L2_adder_data), 32'(exp_data));
    check({tag, ".cout"}, 32'(L2_cout), 32'(exp_cout));
    check({tag, ".ovf"}, 32'(L2_ovf), 32'(exp_ovf));
    check({tag, ".led"}, 32'(L2_led), 32'(exp_led));
    @(negedge clk);
    check({tag, ".rdy_pulse"}, 32'(L2_adder_rdy), 32'd0);
    check({tag, ".idle"}, 32'(L2_busy), 32'd0);
  endtask

  initial begin
    int pulses;
    int last;
    int cyc;
    logic [W-1:0] seen_data;

    Gl_rst = 1'b1; Gl_adder_start = 1'b0; Gl_subtract = 1'b0;
    Gl_r1 = '0; Gl_r2 = '0;
    repeat (2) @(negedge clk);
    check("reset.data", 32'(L2_adder_data), 32'd0);
    check("reset.led", 32'(L2_led), 32'd0);
    check("reset.busy_rdy", {30'd0, L2_busy, L2_adder_rdy}, 32'd0);
    Gl_rst = 1'b0;

    // Basic add, signed overflow, unsigned carry, subtract with borrow.
    do_op("add_5_3",   8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 8'h18);
    do_op("add_7f_1",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8'h2A);
    do_op("add_ff_1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h39);
    do_op("sub_3_5",   8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h4C);

    // Re-pulsing start with new operands mid-RUN must be ignored.
    @(negedge clk);
    Gl_r1 = 8'h05; Gl_r2 = 8'h03; Gl_subtract = 1'b0; Gl_adder_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Gl_adder_start = 1'b0;
    repeat (3) @(negedge clk);
    Gl_r1 = 8'h10; Gl_subtract = 1'b1; Gl_adder_start = 1'b1;
    @(negedge clk);
    Gl_adder_start = 1'b0; Gl_subtract = 1'b0; Gl_r1 = 8'h05;
    pulses = 0; seen_data = '0;
    repeat (15) begin
      @(negedge clk);
      if (L2_adder_rdy) begin
        pulses++;
        seen_data = L2_adder_data;
      end
    end
    check("ignore.pulses", 32'(pulses), 32'd1);
    check("ignore.data", 32'(seen_data), 32'h08);
    check("ignore.hold", 32'(L2_adder_data), 32'h08);
    check("ignore.led", 32'(L2_led), 32'h50);

    // Asynchronous reset at bit 4 of an operation aborts it.
    @(negedge clk);
    Gl_r1 = 8'h40; Gl_r2 = 8'h40; Gl_adder_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Gl_adder_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 Gl_rst = 1'b1;
    #1;
    check("arst.data", 32'(L2_adder_data), 32'd0);
    check("arst.led", 32'(L2_led), 32'd0);
    check("arst.flags", {28'd0, L2_busy, L2_adder_rdy, L2_cout, L2_ovf}, 32'd0);
    @(negedge clk);
    Gl_rst = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (L2_adder_rdy) pulses++;
    end
    check("arst.no_rdy", 32'(pulses), 32'd0);
    do_op("post_rst",  8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 8'h18);

    // Start held high: 17 back-to-back ops, rdy every W+2 cycles, counter wraps.
    @(negedge clk);
    Gl_rst = 1'b1;
    @(negedge clk);
    Gl_rst = 1'b0;
    Gl_r1 = 8'h11; Gl_r2 = 8'h22; Gl_subtract = 1'b0; Gl_adder_start = 1'b1;
    pulses = 0; last = 0; cyc = 0;
    while (pulses < 17 && cyc < 17 * (W + 2) + 30) begin
      @(negedge clk);
      cyc++;
      if (L2_adder_rdy) begin
        if (pulses > 0) check("b2b.spacing", 32'(cyc - last), 32'(W + 2));
        last = cyc;
        pulses++;
      end
    end
    Gl_adder_start = 1'b0;
    check("b2b.pulses", 32'(pulses), 32'd17);
    check("b2b.data", 32'(L2_adder_data), 32'h33);
    check("b2b.count_wrap", 32'(L2_led[7:4]), 32'h1);
    repeat (2) @(negedge clk);
    check("b2b.stopped", 32'(L2_busy), 32'd0);

    // Subtract with signed overflow and no borrow.
    do_op("sub_80_1",  8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h2F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
